// File: rtl/regfile_mp_if.sv
// Bundle of the register file's data, scoreboard and clear-control signals.
// master = datapath driving the register file, slave = the register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic                  clr_req;
  logic                  clr_busy;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [XLEN-1:0]       wdata;
  logic [NREAD*AW-1:0]   raddr;
  logic [NREAD*XLEN-1:0] rdata;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic [NREAD-1:0]      rd_pend;

  modport master (
    output clr_req, we, waddr, wdata, raddr, iss_valid, iss_rd,
    input  clr_busy, rdata, rd_pend
  );

  modport slave (
    input  clr_req, we, waddr, wdata, raddr, iss_valid, iss_rd,
    output clr_busy, rdata, rd_pend
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write bypass, optional x0
// hardwiring, a pending-write scoreboard and a sequential clear engine.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_clr_idx;
  logic [NREGS-1:0]    r_pending;
  logic [XLEN-1:0]     r_mem [NREGS];

  logic                w_busy;
  logic                w_wr_en;
  logic                w_iss_en;
  logic [AW-1:0]       w_raddr [NREAD];
  logic [NREAD*XLEN-1:0] w_rdata;
  logic [NREAD-1:0]    w_pend;

  assign w_busy   = (r_state == S_CLEAR);
  assign w_wr_en  = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign w_iss_en = bus.iss_valid && !((ZERO_REG != 0) && (bus.iss_rd == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
      r_pending <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clr_req) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
          end
          // Set is applied after clear so the newer producer wins on a tie.
          if (w_wr_en)  r_pending[bus.waddr]  <= 1'b0;
          if (w_iss_en) r_pending[bus.iss_rd] <= 1'b1;
        end
        S_CLEAR: begin
          r_pending <= '0;
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == AW'(NREGS - 1)) r_state <= S_IDLE;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Array has no reset; while reset is held the engine sits on index 0.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREAD; i++) begin
      w_raddr[i] = bus.raddr[i*AW +: AW];
    end
  end

  always_comb begin
    w_rdata = '0;
    w_pend  = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (!((ZERO_REG != 0) && (w_raddr[i] == '0)) && !w_busy) begin
        if ((BYPASS != 0) && bus.we && (bus.waddr == w_raddr[i])) begin
          w_rdata[i*XLEN +: XLEN] = bus.wdata;
        end else begin
          w_rdata[i*XLEN +: XLEN] = r_mem[w_raddr[i]];
        end
        w_pend[i] = r_pending[w_raddr[i]];
      end
    end
  end

  assign bus.clr_busy = w_busy;
  assign bus.rdata    = w_rdata;
  assign bus.rd_pend  = w_pend;
endmodule
